multicycle_main_control: RTL and testbench

//  Multicycle MIPS main control FSM. Decodes the 6-bit opcode from the instruction register.

---
 rtl/multicycle_main_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: decodes the IR opcode and sequences the
// per-state datapath controls, stretching memory accesses to MEM_LAT cycles.
module multicycle_main_control #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       aluOP1,
    output logic       aluOP2,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMREAD   = 4'd3,
        MEMWB     = 4'd4,
        MEMWRITE  = 4'd5,
        EXECUTE   = 4'd6,
        RCOMPLETE = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11,
        IDLE      = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [3:0] LAST     = 4'(MEM_LAT - 1);

    state_t     cur, nxt;
    logic [3:0] cnt, nxt_cnt;
    logic [5:0] op_q, nxt_op;
    logic       ill, nxt_ill;
    ctrl_t      ctrl;

    // Control word for a given (state, last-wait-cycle, latched opcode).
    function automatic ctrl_t decode_ctrl(input state_t s, input logic last, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = last;
                c.pc_write  = last;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR, ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMREAD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            RCOMPLETE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_ne     = (op == OP_BNE);
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            ADDI_WB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt     = cur;
        nxt_op  = op_q;
        nxt_ill = ill;
        case (cur)
            IDLE:     nxt = FETCH;
            FETCH:    if (cnt == LAST) nxt = DECODE;
            DECODE: begin
                nxt_op = opcode;
                case (opcode)
                    OP_RTYPE:       nxt = EXECUTE;
                    OP_LW, OP_SW:   nxt = MEMADR;
                    OP_BEQ, OP_BNE: nxt = BRANCH;
                    OP_J:           nxt = JUMP;
                    OP_ADDI:        nxt = ADDI_EX;
                    default: begin
                        nxt     = FETCH;
                        nxt_ill = 1'b1;
                    end
                endcase
            end
            MEMADR:   nxt = (op_q == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (cnt == LAST) nxt = MEMWB;
            MEMWRITE: if (cnt == LAST) nxt = FETCH;
            EXECUTE:  nxt = RCOMPLETE;
            ADDI_EX:  nxt = ADDI_WB;
            default:  nxt = FETCH;
        endcase
        // Only the memory wait states ever hold, so any state change restarts the count.
        nxt_cnt = (nxt == cur) ? cnt + 4'd1 : 4'd0;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur  <= IDLE;
            cnt  <= 4'd0;
            op_q <= 6'd0;
            ill  <= 1'b0;
            ctrl <= '0;
        end else begin
            cur  <= nxt;
            cnt  <= nxt_cnt;
            op_q <= nxt_op;
            ill  <= nxt_ill;
            ctrl <= decode_ctrl(nxt, nxt_cnt == LAST, nxt_op);
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign aluOP1        = ctrl.alu_op[1];
    assign aluOP2        = ctrl.alu_op[0];
    assign illegal_op    = ill;
    assign state         = cur;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Table-driven bench for multicycle_main_control with MEM_LAT = 1, 3 and 4
// instances, plus async-reset and random-stream sequences.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    logic [5:0] op_v [3];
    wire  [21:0] o1, o3, o4;   // {state, 17 control bits, illegal_op}

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.MEM_LAT(1)) u1 (
        .clk(clk), .reset(rst_v[0]), .opcode(op_v[0]),
        .pc_write(o1[17]), .pc_write_cond(o1[16]), .branch_ne(o1[15]), .i_or_d(o1[14]),
        .mem_read(o1[13]), .mem_write(o1[12]), .ir_write(o1[11]), .mem_to_reg(o1[10]),
        .reg_dst(o1[9]), .reg_write(o1[8]), .alu_src_a(o1[7]), .alu_src_b(o1[6:5]),
        .pc_source(o1[4:3]), .aluOP1(o1[2]), .aluOP2(o1[1]), .illegal_op(o1[0]),
        .state(o1[21:18]));

    multicycle_main_control #(.MEM_LAT(3)) u3 (
        .clk(clk), .reset(rst_v[1]), .opcode(op_v[1]),
        .pc_write(o3[17]), .pc_write_cond(o3[16]), .branch_ne(o3[15]), .i_or_d(o3[14]),
        .mem_read(o3[13]), .mem_write(o3[12]), .ir_write(o3[11]), .mem_to_reg(o3[10]),
        .reg_dst(o3[9]), .reg_write(o3[8]), .alu_src_a(o3[7]), .alu_src_b(o3[6:5]),
        .pc_source(o3[4:3]), .aluOP1(o3[2]), .aluOP2(o3[1]), .illegal_op(o3[0]),
        .state(o3[21:18]));

    multicycle_main_control #(.MEM_LAT(4)) u4 (
        .clk(clk), .reset(rst_v[2]), .opcode(op_v[2]),
        .pc_write(o4[17]), .pc_write_cond(o4[16]), .branch_ne(o4[15]), .i_or_d(o4[14]),
        .mem_read(o4[13]), .mem_write(o4[12]), .ir_write(o4[11]), .mem_to_reg(o4[10]),
        .reg_dst(o4[9]), .reg_write(o4[8]), .alu_src_a(o4[7]), .alu_src_b(o4[6:5]),
        .pc_source(o4[4:3]), .aluOP1(o4[2]), .aluOP2(o4[1]), .illegal_op(o4[0]),
        .state(o4[21:18]));

    typedef struct {
        int         inst;
        logic       rst;
        logic [5:0] op;
        logic [3:0] st;
        logic       lst;
        logic       bne;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    // Hand-written control words, order: pcw pcwc bne iord mrd mwr irw m2r rdst rw srca srcb[2] pcsrc[2] op1 op2
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic lst, input logic bne);
        case (st)
            4'd0:    exp_ctrl = lst ? 17'b1_0_0_0_1_0_1_0_0_0_0_01_00_0_0
                                    : 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_0_0;
            4'd1:    exp_ctrl = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_0_0;
            4'd2:    exp_ctrl = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_0_0;
            4'd3:    exp_ctrl = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_0_0;
            4'd4:    exp_ctrl = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_0_0;
            4'd5:    exp_ctrl = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_0_0;
            4'd6:    exp_ctrl = 17'b0_0_0_0_0_0_0_0_0_0_1_00_00_1_0;
            4'd7:    exp_ctrl = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_0_0;
            4'd8:    exp_ctrl = bne ? 17'b0_1_1_0_0_0_0_0_0_0_1_00_01_0_1
                                    : 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_0_1;
            4'd9:    exp_ctrl = 17'b1_0_0_0_0_0_0_0_0_0_0_00_10_0_0;
            4'd10:   exp_ctrl = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_0_0;
            4'd11:   exp_ctrl = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_0_0;
            default: exp_ctrl = 17'b0;
        endcase
    endfunction

    function automatic int exp_cpi(input logic [5:0] op, input int lat);
        case (op)
            6'b000000: exp_cpi = lat + 3;
            6'b100011: exp_cpi = 2 * lat + 3;
            6'b101011: exp_cpi = 2 * lat + 2;
            6'b000100: exp_cpi = lat + 2;
            6'b000101: exp_cpi = lat + 2;
            6'b000010: exp_cpi = lat + 2;
            6'b001000: exp_cpi = lat + 3;
            default:   exp_cpi = lat + 1;
        endcase
    endfunction

    function automatic logic [21:0] sel(input int i);
        case (i)
            0:       sel = o1;
            1:       sel = o3;
            default: sel = o4;
        endcase
    endfunction

    function automatic void add(input int inst, input logic rst, input logic [5:0] op,
                                input logic [3:0] st, input logic lst, input logic bne,
                                input logic ill);
        vec_t v;
        v.inst = inst; v.rst = rst; v.op = op; v.st = st;
        v.lst = lst;   v.bne = bne; v.ill = ill;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    initial begin
        logic [21:0] obs;
        logic [3:0]  prev, s;
        logic [5:0]  rop, dec_op;
        logic        started;
        int          cyc;

        op_v[0] = 6'd0; op_v[1] = 6'd0; op_v[2] = 6'd0;

        // u1 (MEM_LAT=1): R-type, beq, bne, illegal, j, lw, addi, sw
        add(0, 1, 6'o00, 15, 0, 0, 0);
        add(0, 0, 6'b000000, 0, 1, 0, 0);
        add(0, 0, 6'b000000, 1, 0, 0, 0);
        add(0, 0, 6'b000000, 6, 0, 0, 0);
        add(0, 0, 6'b000000, 7, 0, 0, 0);
        add(0, 0, 6'b000000, 0, 1, 0, 0);
        add(0, 0, 6'b000100, 1, 0, 0, 0);
        add(0, 0, 6'b000100, 8, 0, 0, 0);
        add(0, 0, 6'b000101, 0, 1, 0, 0);
        add(0, 0, 6'b000101, 1, 0, 0, 0);
        add(0, 0, 6'b000101, 8, 0, 1, 0);
        add(0, 0, 6'b111111, 0, 1, 0, 0);
        add(0, 0, 6'b111111, 1, 0, 0, 0);
        add(0, 0, 6'b111111, 0, 1, 0, 1);
        add(0, 0, 6'b000010, 1, 0, 0, 1);
        add(0, 0, 6'b000010, 9, 0, 0, 1);
        add(0, 0, 6'b001000, 0, 1, 0, 1);
        add(0, 0, 6'b100011, 1, 0, 0, 1);
        add(0, 0, 6'b100011, 2, 0, 0, 1);
        add(0, 0, 6'b001000, 3, 1, 0, 1);
        add(0, 0, 6'b101011, 4, 0, 0, 1);
        add(0, 0, 6'b001000, 0, 1, 0, 1);
        add(0, 0, 6'b001000, 1, 0, 0, 1);
        add(0, 0, 6'b001000, 10, 0, 0, 1);
        add(0, 0, 6'b101011, 11, 0, 0, 1);
        add(0, 0, 6'b101011, 0, 1, 0, 1);
        add(0, 0, 6'b101011, 1, 0, 0, 1);
        add(0, 0, 6'b101011, 2, 0, 0, 1);
        add(0, 0, 6'b101011, 5, 1, 0, 1);
        add(0, 0, 6'b101011, 0, 1, 0, 1);
        // u3 (MEM_LAT=3): lw takes 9 cycles
        add(1, 1, 6'b100011, 15, 0, 0, 0);
        add(1, 0, 6'b100011, 0, 0, 0, 0);
        add(1, 0, 6'b100011, 0, 0, 0, 0);
        add(1, 0, 6'b100011, 0, 1, 0, 0);
        add(1, 0, 6'b100011, 1, 0, 0, 0);
        add(1, 0, 6'b100011, 2, 0, 0, 0);
        add(1, 0, 6'b100011, 3, 0, 0, 0);
        add(1, 0, 6'b100011, 3, 0, 0, 0);
        add(1, 0, 6'b100011, 3, 1, 0, 0);
        add(1, 0, 6'b100011, 4, 0, 0, 0);
        add(1, 0, 6'b100011, 0, 0, 0, 0);
        // u4 (MEM_LAT=4): sw up to the middle of MEMWRITE
        add(2, 1, 6'b101011, 15, 0, 0, 0);
        add(2, 0, 6'b101011, 0, 0, 0, 0);
        add(2, 0, 6'b101011, 0, 0, 0, 0);
        add(2, 0, 6'b101011, 0, 0, 0, 0);
        add(2, 0, 6'b101011, 0, 1, 0, 0);
        add(2, 0, 6'b101011, 1, 0, 0, 0);
        add(2, 0, 6'b101011, 2, 0, 0, 0);
        add(2, 0, 6'b101011, 5, 0, 0, 0);
        add(2, 0, 6'b101011, 5, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_v[vecs[i].inst] = vecs[i].rst;
            op_v[vecs[i].inst]  = vecs[i].op;
            @(posedge clk);
            #1;
            obs = sel(vecs[i].inst);
            check($sformatf("vec%0d_u%0d", i, vecs[i].inst), 32'(obs),
                  32'({vecs[i].st, exp_ctrl(vecs[i].st, vecs[i].lst, vecs[i].bne), vecs[i].ill}));
        end

        // Async reset in the middle of the MEMWRITE wait takes effect before the next edge
        rst_v[2] = 1'b1;
        #1;
        check("async_reset_now", 32'(o4), 32'h003C0000);
        @(posedge clk);
        #1;
        check("reset_held", 32'(o4), 32'h003C0000);
        rst_v[2] = 1'b0;
        @(posedge clk);
        #1;
        check("fetch_after_release", 32'(o4), 32'({4'd0, exp_ctrl(4'd0, 1'b0, 1'b0), 1'b0}));

        // Random opcode stream on the MEM_LAT=3 instance
        prev    = o3[21:18];
        started = 1'b0;
        dec_op  = 6'd0;
        cyc     = 0;
        for (int c = 0; c < 2000; c++) begin
            case ($urandom_range(0, 7))
                0: rop = 6'b000000;
                1: rop = 6'b100011;
                2: rop = 6'b101011;
                3: rop = 6'b000100;
                4: rop = 6'b000101;
                5: rop = 6'b000010;
                6: rop = 6'b001000;
                default: rop = 6'b111111;
            endcase
            op_v[1] = rop;
            @(posedge clk);
            #1;
            s = o3[21:18];
            if (prev == 4'd1) dec_op = rop;
            check("invariants", 32'((o3[13] & o3[12]) | (o3[17] & o3[16]) | (o3[2] & o3[1])), 32'd0);
            if (s == 4'd0 && prev != 4'd0) begin
                if (started) check($sformatf("cpi_op%b", dec_op), 32'(cyc), 32'(exp_cpi(dec_op, 3)));
                started = 1'b1;
                cyc = 1;
            end else begin
                cyc++;
            end
            prev = s;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
